// File: rtl/tl45_rf_pkg.sv
// Shared types and helpers for the tl45 multi-port register file.
// Optional parity protection is built when TL45_RF_PARITY_EN is defined.
package tl45_rf_pkg;

    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_IDLE  = 1'b1
    } rf_state_t;

    // Widest data word the parity helper accepts; narrower words are zero-extended.
    localparam int RF_MAX_DW = 128;

    function automatic logic rf_addr_valid(input logic [8:0] addr, input int nregs);
        return (addr != 9'd0) && (int'(addr) < nregs);
    endfunction

    function automatic logic rf_parity(input logic [RF_MAX_DW-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/tl45_rf_read_port.sv
// One registered read port: address decode, write-first bypass, output register, parity check.
// Latency 1; holds its output while rd_en is low and outputs zero until the file is idle.
module tl45_rf_read_port
    import tl45_rf_pkg::*;
#(
    parameter int DW     = 32,
    parameter int NREGS  = 16,
    parameter int AW     = 4,
    parameter int NWRITE = 1,
    parameter int EW     = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_idle,
    input  logic                 i_rd_en,
    input  logic [AW-1:0]        i_rd_addr,
    input  logic [EW-1:0]        i_mem [1:NREGS-1],
    input  logic [NWRITE-1:0]    i_wr_vld,
    input  logic [NWRITE*AW-1:0] i_wr_addr,
    input  logic [NWRITE*DW-1:0] i_wr_data,
    output logic [DW-1:0]        o_rd_data,
    output logic                 o_rd_perr
);

    logic          w_hit;
    logic          w_valid;
    logic [DW-1:0] w_byp_data;
    logic [EW-1:0] w_entry;
    logic [DW-1:0] w_data;
    logic          w_perr;

    always_comb begin
        w_hit      = 1'b0;
        w_byp_data = '0;
        // Ascending scan so the highest-indexed matching writer supplies the bypass.
        for (int w = 0; w < NWRITE; w++) begin
            if (i_wr_vld[w] && (i_wr_addr[w*AW +: AW] == i_rd_addr)) begin
                w_hit      = 1'b1;
                w_byp_data = i_wr_data[w*DW +: DW];
            end
        end
        w_valid = rf_addr_valid(9'(i_rd_addr), NREGS);
        w_entry = w_valid ? i_mem[i_rd_addr] : '0;
        w_data  = w_hit ? w_byp_data : w_entry[DW-1:0];
`ifdef TL45_RF_PARITY_EN
        w_perr  = !w_hit && w_valid && (rf_parity(RF_MAX_DW'(w_entry[DW-1:0])) != w_entry[DW]);
`else
        w_perr  = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset || !i_idle) begin
            o_rd_data <= '0;
            o_rd_perr <= 1'b0;
        end else if (i_rd_en) begin
            o_rd_data <= w_data;
            o_rd_perr <= w_perr;
        end
    end

endmodule

// File: rtl/tl45_regfile_mp.sv
// Multi-port tl45 register file: r0 hardwired zero, registered write-first reads, swept clear after reset.
// Latency 1 read; writes and rd_data are suppressed until ready (optional parity via TL45_RF_PARITY_EN).
module tl45_regfile_mp
    import tl45_rf_pkg::*;
#(
    parameter int  DW     = 32,
    parameter int  NREGS  = 16,
    parameter int  NREAD  = 2,
    parameter int  NWRITE = 1,
    localparam int AW     = $clog2(NREGS)
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic                 ready,
    input  logic [NREAD-1:0]     rd_en,
    input  logic [NREAD*AW-1:0]  rd_addr,
    output logic [NREAD*DW-1:0]  rd_data,
    output logic [NREAD-1:0]     rd_perr,
    input  logic [NWRITE-1:0]    wr_en,
    input  logic [NWRITE*AW-1:0] wr_addr,
    input  logic [NWRITE*DW-1:0] wr_data
);

`ifdef TL45_RF_PARITY_EN
    localparam int EW = DW + 1;
`else
    localparam int EW = DW;
`endif
    localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

    logic [EW-1:0] r_mem [1:NREGS-1];
    rf_state_t     r_state;
    rf_state_t     w_state_nxt;
    logic [AW-1:0] r_cnt;
    logic [AW-1:0] w_cnt_nxt;
    logic          r_ready;
    logic [NWRITE-1:0] w_wr_vld;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= RF_CLEAR;
            r_cnt   <= AW'(1);
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ready <= (w_state_nxt == RF_IDLE);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            RF_CLEAR: begin
                if (r_cnt == LAST) w_state_nxt = RF_IDLE;
                else               w_cnt_nxt   = r_cnt + AW'(1);
            end
            default: ;
        endcase
    end

    always_comb begin
        for (int w = 0; w < NWRITE; w++) begin
            w_wr_vld[w] = (r_state == RF_IDLE) && wr_en[w] &&
                          rf_addr_valid(9'(wr_addr[w*AW +: AW]), NREGS);
        end
    end

    // No reset branch: the sweep is the only initialisation of storage.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (r_state == RF_CLEAR) begin
                r_mem[r_cnt] <= '0;
            end else begin
                for (int w = 0; w < NWRITE; w++) begin
                    if (w_wr_vld[w]) begin
`ifdef TL45_RF_PARITY_EN
                        r_mem[wr_addr[w*AW +: AW]] <= {rf_parity(RF_MAX_DW'(wr_data[w*DW +: DW])),
                                                       wr_data[w*DW +: DW]};
`else
                        r_mem[wr_addr[w*AW +: AW]] <= wr_data[w*DW +: DW];
`endif
                    end
                end
            end
        end
    end

    for (genvar p = 0; p < NREAD; p++) begin : g_rd
        tl45_rf_read_port #(
            .DW     (DW),
            .NREGS  (NREGS),
            .AW     (AW),
            .NWRITE (NWRITE),
            .EW     (EW)
        ) u_port (
            .clk       (clk),
            .reset     (reset),
            .i_idle    (r_state == RF_IDLE),
            .i_rd_en   (rd_en[p]),
            .i_rd_addr (rd_addr[p*AW +: AW]),
            .i_mem     (r_mem),
            .i_wr_vld  (w_wr_vld),
            .i_wr_addr (wr_addr),
            .i_wr_data (wr_data),
            .o_rd_data (rd_data[p*DW +: DW]),
            .o_rd_perr (rd_perr[p])
        );
    end

    assign ready = r_ready;

endmodule

// File: tb/tb_tl45_regfile_mp.sv
// Directed bench for tl45_regfile_mp with two read and two write ports.
module tb_tl45_regfile_mp;

    localparam int DW = 32;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          ready;
    logic [1:0]    rd_en;
    logic [7:0]    rd_addr;
    logic [63:0]   rd_data;
    logic [1:0]    rd_perr;
    logic [1:0]    wr_en;
    logic [7:0]    wr_addr;
    logic [63:0]   wr_data;

    int n_checks = 0;
    int n_errors = 0;
    int cnt;

    always #5 clk = ~clk;

    tl45_regfile_mp #(
        .DW(DW), .NREGS(16), .NREAD(2), .NWRITE(2)
    ) dut (
        .clk(clk), .reset(reset), .ready(ready),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_perr(rd_perr),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!ready && n < 100) begin
            tick();
            n++;
        end
    endtask

    task automatic rd(input logic [3:0] a0, input logic [3:0] a1);
        rd_en   = 2'b11;
        rd_addr = {a1, a0};
    endtask

    task automatic wr(input logic [1:0] en, input logic [3:0] a0, input logic [31:0] d0,
                      input logic [3:0] a1, input logic [31:0] d1);
        wr_en   = en;
        wr_addr = {a1, a0};
        wr_data = {d1, d0};
    endtask

    initial begin
        reset = 1'b1;
        rd_en = '0; rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
        repeat (3) tick();
        chk("reset_ready", 64'(ready), 64'd0);
        chk("reset_rd_data", rd_data, 64'd0);
        chk("reset_rd_perr", 64'(rd_perr), 64'd0);

        reset = 1'b0;
        wait_ready(cnt);
        chk("sweep_cycles", 64'(cnt), 64'd15);

        for (int a = 1; a < 16; a++) begin
            rd(4'(a), 4'(a));
            tick();
            chk($sformatf("clear_r%0d", a), rd_data, 64'd0);
        end

        wr(2'b01, 4'd5, 32'hDEADBEEF, 4'd0, 32'd0);
        tick();
        wr(2'b00, 4'd0, 32'd0, 4'd0, 32'd0);
        rd(4'd5, 4'd0);
        tick();
        chk("rd_r5", 64'(rd_data[31:0]), 64'hDEADBEEF);
        chk("rd_r0_port1", 64'(rd_data[63:32]), 64'd0);

        wr(2'b01, 4'd0, 32'h1234, 4'd0, 32'd0);
        tick();
        wr(2'b00, 4'd0, 32'd0, 4'd0, 32'd0);
        rd(4'd0, 4'd0);
        tick();
        chk("rd_r0_after_write", rd_data, 64'd0);

        wr(2'b01, 4'd7, 32'hA5A5A5A5, 4'd0, 32'd0);
        rd(4'd7, 4'd7);
        tick();
        wr(2'b00, 4'd0, 32'd0, 4'd0, 32'd0);
        chk("bypass_r7_both", rd_data, 64'hA5A5A5A5_A5A5A5A5);

        rd_en   = 2'b00;
        rd_addr = {4'd5, 4'd5};
        tick();
        chk("hold_rd_en_low", rd_data, 64'hA5A5A5A5_A5A5A5A5);

        wr(2'b11, 4'd3, 32'h11, 4'd3, 32'h22);
        tick();
        wr(2'b00, 4'd0, 32'd0, 4'd0, 32'd0);
        rd(4'd3, 4'd5);
        tick();
        chk("conflict_r3", rd_data, {32'hDEADBEEF, 32'h22});

        wr(2'b11, 4'd6, 32'h33, 4'd6, 32'h44);
        rd(4'd6, 4'd3);
        tick();
        wr(2'b00, 4'd0, 32'd0, 4'd0, 32'd0);
        chk("conflict_bypass_r6", rd_data, {32'h22, 32'h44});

`ifdef TL45_RF_PARITY_EN
        wr(2'b11, 4'd9, 32'h0000000F, 4'd4, 32'h00000007);
        tick();
        wr(2'b00, 4'd0, 32'd0, 4'd0, 32'd0);
        dut.r_mem[9] = dut.r_mem[9] ^ 33'd1;
        rd(4'd9, 4'd4);
        tick();
        chk("perr_r9_data", 64'(rd_data[31:0]), 64'h0000000E);
        chk("perr_flags", 64'(rd_perr), 64'b01);
`else
        rd(4'd5, 4'd6);
        tick();
        chk("perr_tied_off", 64'(rd_perr), 64'd0);
`endif

        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (8) tick();
        chk("mid_sweep_ready", 64'(ready), 64'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        wr(2'b01, 4'd2, 32'hCAFEF00D, 4'd2, 32'h0BADF00D);
        rd(4'd5, 4'd6);
        tick();
        chk("clear_rd_forced_zero", rd_data, 64'd0);
        wait_ready(cnt);
        chk("restart_sweep_cycles", 64'(cnt + 1), 64'd15);
        wr(2'b00, 4'd0, 32'd0, 4'd0, 32'd0);
        rd(4'd2, 4'd5);
        tick();
        chk("write_in_clear_lost", rd_data, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
